// File: rtl/wb_port_arbiter_pkg.sv
// rtl/wb_port_arbiter_pkg.sv - shared encodings and widths for the writeback port arbiter
package wb_port_arbiter_pkg;

  // Core-wide register index and data widths
  localparam int RS_W_DEF = 5;
  localparam int XLEN_DEF = 32;

  // Arbiter FSM: NORMAL applies priority rules, FORCE drains a starved MDU result
  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } arb_state_t;

  // Source tag carried alongside each register-file write
  localparam logic SRC_PIPE = 1'b0;
  localparam logic SRC_MDU  = 1'b1;

endpackage

// File: rtl/wb_starve_counter.sv
// rtl/wb_starve_counter.sv - saturating MDU wait counter with force request
module wb_starve_counter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic m_valid,
  input  logic m_grant,
  output logic force_req
);

  localparam logic [3:0] SAT = 4'(STARVE_LIMIT - 1);

  logic [3:0] wait_cnt;

  // Count consecutive denied MDU cycles; any grant or idle cycle restarts the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 4'd0;
    end else if (!m_valid || m_grant) begin
      wait_cnt <= 4'd0;
    end else if (wait_cnt != SAT) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // The MDU has waited long enough and is being denied yet again
  assign force_req = m_valid && !m_grant && (wait_cnt == SAT);

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter between pipeline and MDU
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int RS_W         = RS_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            p_valid_i,
  input  logic [RS_W-1:0] p_rd_i,
  input  logic [XLEN-1:0] p_data_i,
  output logic            p_ready_o,
  input  logic            m_valid_i,
  input  logic [RS_W-1:0] m_rd_i,
  input  logic [XLEN-1:0] m_data_i,
  output logic            m_ready_o,
  input  logic            flush_i,
  output logic            w_wen_o,
  output logic [RS_W-1:0] w_rd_o,
  output logic [XLEN-1:0] w_data_o,
  output logic            w_src_o,
  output logic            starve_o
);

  arb_state_t state;
  arb_state_t state_next;
  logic       grant_p;
  logic       grant_m;
  logic       force_req;
  logic       p_live;

  // A flushed pipeline request is simply not a contender this cycle
  assign p_live = p_valid_i && !flush_i;

  wb_starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .m_valid  (m_valid_i),
    .m_grant  (grant_m),
    .force_req(force_req)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_NORMAL;
    end else begin
      state <= state_next;
    end
  end

  // FORCE lasts exactly one cycle and is only entered from NORMAL
  always_comb begin
    state_next = ST_NORMAL;
    if (state == ST_NORMAL && force_req) begin
      state_next = ST_FORCE;
    end
  end

  // Grant selection; same-destination conflict goes to the older MDU result
  always_comb begin
    grant_p = 1'b0;
    grant_m = 1'b0;
    if (!rst) begin
      if (state == ST_FORCE) begin
        grant_m = m_valid_i;
      end else if (p_live && m_valid_i && (p_rd_i == m_rd_i) && (p_rd_i != '0)) begin
        grant_m = 1'b1;
      end else if (p_live) begin
        grant_p = 1'b1;
      end else if (m_valid_i) begin
        grant_m = 1'b1;
      end
    end
  end

  assign p_ready_o = grant_p;
  assign m_ready_o = grant_m;
  assign starve_o  = (state == ST_FORCE);

  // Registered write command; x0 writes are consumed but never enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_wen_o  <= 1'b0;
      w_rd_o   <= '0;
      w_data_o <= '0;
      w_src_o  <= SRC_PIPE;
    end else if (grant_p) begin
      w_wen_o  <= (p_rd_i != '0);
      w_rd_o   <= p_rd_i;
      w_data_o <= p_data_i;
      w_src_o  <= SRC_PIPE;
    end else if (grant_m) begin
      w_wen_o  <= (m_rd_i != '0);
      w_rd_o   <= m_rd_i;
      w_data_o <= m_data_i;
      w_src_o  <= SRC_MDU;
    end else begin
      w_wen_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - randomized self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

  localparam int XLEN  = 32;
  localparam int RS_W  = 5;
  localparam int LIMIT = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            p_valid;
  logic [RS_W-1:0] p_rd;
  logic [XLEN-1:0] p_data;
  logic            p_ready;
  logic            m_valid;
  logic [RS_W-1:0] m_rd;
  logic [XLEN-1:0] m_data;
  logic            m_ready;
  logic            flush;
  logic            w_wen;
  logic [RS_W-1:0] w_rd;
  logic [XLEN-1:0] w_data;
  logic            w_src;
  logic            starve;

  wb_port_arbiter #(
    .XLEN(XLEN), .RS_W(RS_W), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .p_valid_i(p_valid), .p_rd_i(p_rd), .p_data_i(p_data), .p_ready_o(p_ready),
    .m_valid_i(m_valid), .m_rd_i(m_rd), .m_data_i(m_data), .m_ready_o(m_ready),
    .flush_i(flush),
    .w_wen_o(w_wen), .w_rd_o(w_rd), .w_data_o(w_data), .w_src_o(w_src),
    .starve_o(starve)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: length of the current run of denied MDU cycles and the expected write port
  int              streak;
  logic            e_wen;
  logic [RS_W-1:0] e_rd;
  logic [XLEN-1:0] e_data;
  logic            e_src;
  logic            gp, gm, fz;
  logic [XLEN-1:0] rf [32];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    streak = 0;
    e_wen  = 1'b0;
    e_rd   = '0;
    e_data = '0;
    e_src  = 1'b0;
  endtask

  task automatic drive(input logic pv, input logic [RS_W-1:0] prd, input logic [XLEN-1:0] pd,
                       input logic mv, input logic [RS_W-1:0] mrd, input logic [XLEN-1:0] md,
                       input logic fl);
    @(negedge clk);
    p_valid = pv; p_rd = prd; p_data = pd;
    m_valid = mv; m_rd = mrd; m_data = md;
    flush = fl;
    #1;
  endtask

  // Decide this cycle's winner from the arbitration rules and check the combinational outputs
  task automatic eval_ready(input string tag);
    logic pe;
    pe = p_valid && !flush;
    fz = (streak >= LIMIT);
    gp = 1'b0;
    gm = 1'b0;
    if (fz) gm = m_valid;
    else if (pe && m_valid && p_rd == m_rd && p_rd != 0) gm = 1'b1;
    else if (pe) gp = 1'b1;
    else if (m_valid) gm = 1'b1;
    check({tag, "/p_ready"}, p_ready, gp);
    check({tag, "/m_ready"}, m_ready, gm);
    check({tag, "/starve"}, starve, fz);
  endtask

  // Clock once, advance the model and check the registered write command
  task automatic step(input string tag);
    @(posedge clk);
    if (gp) begin
      e_wen = (p_rd != 0); e_rd = p_rd; e_data = p_data; e_src = 1'b0;
    end else if (gm) begin
      e_wen = (m_rd != 0); e_rd = m_rd; e_data = m_data; e_src = 1'b1;
    end else begin
      e_wen = 1'b0;
    end
    streak = (m_valid && !gm) ? streak + 1 : 0;
    #1;
    check({tag, "/w_wen"}, w_wen, e_wen);
    check({tag, "/w_rd"}, w_rd, e_rd);
    check({tag, "/w_data"}, w_data, e_data);
    check({tag, "/w_src"}, w_src, e_src);
    if (w_wen) rf[w_rd] = w_data;
  endtask

  task automatic cycle(input string tag, input logic pv, input logic [RS_W-1:0] prd,
                       input logic [XLEN-1:0] pd, input logic mv, input logic [RS_W-1:0] mrd,
                       input logic [XLEN-1:0] md, input logic fl);
    drive(pv, prd, pd, mv, mrd, md, fl);
    eval_ready(tag);
    step(tag);
  endtask

  initial begin
    logic            pp, mp, fl;
    logic [RS_W-1:0] prd, mrd;
    logic [XLEN-1:0] pd, md;

    for (int i = 0; i < 32; i++) rf[i] = '0;
    rst = 1'b1;
    p_valid = 0; p_rd = 0; p_data = 0;
    m_valid = 0; m_rd = 0; m_data = 0; flush = 0;
    model_reset();
    #7;
    check("reset/w_wen", w_wen, 0);
    check("reset/w_rd", w_rd, 0);
    check("reset/w_data", w_data, 0);
    check("reset/w_src", w_src, 0);
    check("reset/starve", starve, 0);
    check("reset/p_ready", p_ready, 0);
    check("reset/m_ready", m_ready, 0);
    @(negedge clk);
    rst = 1'b0;

    // Pipeline alone
    for (int i = 0; i < 3; i++) cycle("pipe_only", 1, 5, 32'h1234, 0, 0, 0, 0);

    // Contention on distinct registers: MDU forced through after LIMIT denied cycles
    for (int i = 0; i < 6; i++) begin
      drive(1, 3, 32'h33, 1, 7, 32'h77, 0);
      eval_ready("contend");
      if (i == 4) check("contend/force_cycle", starve, 1);
      step("contend");
      if (i == 4) check("contend/force_wrd", w_rd, 7);
    end

    // Same destination: older MDU result lands first
    cycle("same_rd_m", 1, 9, 32'hA, 1, 9, 32'hB, 0);
    check("same_rd/first", w_data, 32'hB);
    cycle("same_rd_p", 1, 9, 32'hA, 0, 0, 0, 0);
    check("same_rd/x9", rf[9], 32'hA);

    // Writes to x0 are consumed without enabling the port
    cycle("rd_zero", 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0);
    check("rd_zero/wen", w_wen, 0);

    // Flush with and without MDU traffic
    cycle("flush_m", 1, 2, 32'h22, 1, 4, 32'h44, 1);
    cycle("flush_idle", 1, 2, 32'h22, 0, 0, 0, 1);

    // Asynchronous reset while in FORCE
    for (int i = 0; i < 4; i++) cycle("pre_rst", 1, 3, 32'h33, 1, 7, 32'h77, 0);
    drive(1, 3, 32'h33, 1, 7, 32'h77, 0);
    eval_ready("in_force");
    rst = 1'b1;
    #1;
    check("arst/w_wen", w_wen, 0);
    check("arst/w_rd", w_rd, 0);
    check("arst/w_data", w_data, 0);
    check("arst/starve", starve, 0);
    check("arst/m_ready", m_ready, 0);
    rst = 1'b0;
    model_reset();
    #1;
    eval_ready("post_rst");
    check("post_rst/p_first", p_ready, 1);
    step("post_rst");

    // Randomized traffic; requests hold until granted, flushed pipeline requests are dropped
    pp = 0; mp = 0; prd = 0; mrd = 0; pd = 0; md = 0;
    for (int n = 0; n < 600; n++) begin
      if (!pp && $urandom_range(0, 9) < 6) begin
        pp = 1; prd = RS_W'($urandom_range(0, 7)); pd = $urandom;
      end
      if (!mp && $urandom_range(0, 9) < 4) begin
        mp = 1; mrd = RS_W'($urandom_range(0, 7)); md = $urandom;
      end
      fl = ($urandom_range(0, 9) == 0);
      cycle("rand", pp, prd, pd, mp, mrd, md, fl);
      if (pp && (gp || fl)) pp = 0;
      if (mp && gm) mp = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
